// File: rtl/norm_lshift_iter.sv
// norm_lshift_iter: iterative leading-zero normaliser.
// Takes a mantissa on a start pulse and shifts it left by up to
// SHIFT_STEP bits per cycle until its MSB is set. It then reports the
// normalised value, the total shift and a zero flag, and pulses done.
// Optional feature macro: NORM_LIMIT_EN. It adds a lim input that caps
// the total shift, and a limited flag that is set when the cap is hit
// while the MSB is still 0.
//
// Handshake: start is sampled only in IDLE. busy rises on the accepting
// edge and falls on the edge that enters DONE. done is a one-cycle pulse
// in the cycle after that edge. A new start is accepted from the cycle
// after done. Results hold their value until the next completion.
module norm_lshift_iter #(
  parameter int WIDTH      = 26,
  parameter int CNT_W      = 5,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
`ifdef NORM_LIMIT_EN
  input  logic [CNT_W-1:0] lim,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] shamt,
  output logic             zero,
`ifdef NORM_LIMIT_EN
  output logic             limited,
`endif
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] cnt;
  logic             z;
  logic [CNT_W-1:0] k;
  logic             stop;
`ifdef NORM_LIMIT_EN
  logic [CNT_W-1:0] lim_q;
  logic [CNT_W-1:0] rem;
`endif

  assign fsm_state = state;

  // Step size for this cycle: the leading zeros in the top SHIFT_STEP bits,
  // so no set bit is ever shifted out. Also decide whether shifting stops.
  always_comb begin
    k = CNT_W'(SHIFT_STEP);
    for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
      if (s[WIDTH-1-i]) k = CNT_W'(i);
    end
    stop = z | s[WIDTH-1];
`ifdef NORM_LIMIT_EN
    rem = lim_q - cnt;
    if (rem < k) k = rem;
    stop = stop | (cnt == lim_q);
`endif
  end

  // Control FSM, working registers and registered results.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      s       <= '0;
      cnt     <= '0;
      z       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= '0;
      shamt   <= '0;
      zero    <= 1'b0;
`ifdef NORM_LIMIT_EN
      lim_q   <= '0;
      limited <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            s     <= din;
            cnt   <= '0;
            z     <= (din == '0);
`ifdef NORM_LIMIT_EN
            lim_q <= lim;
`endif
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (stop) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            dout    <= s;
            shamt   <= cnt;
            zero    <= z;
`ifdef NORM_LIMIT_EN
            limited <= ~z & ~s[WIDTH-1];
`endif
          end else begin
            s   <= s << k;
            cnt <= cnt + k;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_lshift_iter.sv
// tb_norm_lshift_iter: bench for norm_lshift_iter with two instances,
// SHIFT_STEP=1 and SHIFT_STEP=4. It runs directed cases followed by random
// mantissas. The expected results come from a leading-zero-count model.
// The bench follows NORM_LIMIT_EN so that it matches the DUT build.
module tb_norm_lshift_iter;
  localparam int W  = 26;
  localparam int CW = 5;

  logic              clk;
  logic              reset;
  logic [1:0]        start_v;
  logic [W-1:0]      din_v   [2];
  logic [CW-1:0]     lim_v   [2];
  logic [1:0]        busy_v;
  logic [1:0]        done_v;
  logic [W-1:0]      dout_v  [2];
  logic [CW-1:0]     shamt_v [2];
  logic [1:0]        zero_v;
  logic [1:0]        limited_v;
  logic [1:0]        st_v    [2];

  int checks   = 0;
  int failures = 0;
  int step_of [2] = '{1, 4};
  logic [W-1:0]  prev_dout  [2];
  logic [CW-1:0] prev_shamt [2];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  norm_lshift_iter #(.WIDTH(W), .CNT_W(CW), .SHIFT_STEP(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .din(din_v[0]),
`ifdef NORM_LIMIT_EN
    .lim(lim_v[0]), .limited(limited_v[0]),
`endif
    .busy(busy_v[0]), .done(done_v[0]), .dout(dout_v[0]),
    .shamt(shamt_v[0]), .zero(zero_v[0]), .fsm_state(st_v[0])
  );

  norm_lshift_iter #(.WIDTH(W), .CNT_W(CW), .SHIFT_STEP(4)) u_s4 (
    .clk(clk), .reset(reset), .start(start_v[1]), .din(din_v[1]),
`ifdef NORM_LIMIT_EN
    .lim(lim_v[1]), .limited(limited_v[1]),
`endif
    .busy(busy_v[1]), .done(done_v[1]), .dout(dout_v[1]),
    .shamt(shamt_v[1]), .zero(zero_v[1]), .fsm_state(st_v[1])
  );

`ifndef NORM_LIMIT_EN
  assign limited_v = 2'b00;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // count of leading zeros, WIDTH for an all-zero word
  function automatic int clz(input logic [W-1:0] v);
    int n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) break;
      n++;
    end
    return n;
  endfunction

  // Drive one request into instance sel and check it against the model.
  // If poke is set, a start with din=0 is pulsed while the DUT is busy.
  task automatic run_op(input int sel, input logic [W-1:0] d, input logic [CW-1:0] lm,
                        input bit poke);
    int l, sh, lat, n;
    bit use_lim, got_done, exp_lim;
    logic [W-1:0] exp_d;
    string pfx;
    pfx = $sformatf("s%0d_%07h", step_of[sel], d);
`ifdef NORM_LIMIT_EN
    use_lim = 1'b1;
`else
    use_lim = 1'b0;
`endif
    l = clz(d);
    if (d == '0) begin
      sh = 0; exp_lim = 1'b0; lat = 1;
    end else begin
      sh = (use_lim && int'(lm) < l) ? int'(lm) : l;
      exp_lim = use_lim && (int'(lm) < l);
      lat = (sh + step_of[sel] - 1) / step_of[sel] + 1;
    end
    exp_d = d << sh;

    @(negedge clk);
    start_v[sel] = 1'b1;
    din_v[sel]   = d;
    lim_v[sel]   = lm;
    @(posedge clk);
    @(negedge clk);
    start_v[sel] = poke;
    din_v[sel]   = '0;
    check({pfx, "_busy_hi"}, 32'(busy_v[sel]), 32'd1);
    check({pfx, "_hold_dout"}, 32'(dout_v[sel]), 32'(prev_dout[sel]));
    check({pfx, "_hold_shamt"}, 32'(shamt_v[sel]), 32'(prev_shamt[sel]));
    n = 0;
    got_done = 1'b0;
    while (n < 100 && !got_done) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start_v[sel] = 1'b0;
      got_done = done_v[sel];
    end
    check({pfx, "_done_seen"}, 32'(got_done), 32'd1);
    check({pfx, "_latency"}, 32'(n), 32'(lat));
    check({pfx, "_dout"}, 32'(dout_v[sel]), 32'(exp_d));
    check({pfx, "_shamt"}, 32'(shamt_v[sel]), 32'(sh));
    check({pfx, "_zero"}, 32'(zero_v[sel]), 32'(d == '0));
    check({pfx, "_busy_lo"}, 32'(busy_v[sel]), 32'd0);
`ifdef NORM_LIMIT_EN
    check({pfx, "_limited"}, 32'(limited_v[sel]), 32'(exp_lim));
`endif
    prev_dout[sel]  = exp_d;
    prev_shamt[sel] = CW'(sh);
    @(negedge clk);
    check({pfx, "_done_pulse"}, 32'(done_v[sel]), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    for (int j = 0; j < 2; j++) begin
      check({tag, "_busy"}, 32'(busy_v[j]), 32'd0);
      check({tag, "_done"}, 32'(done_v[j]), 32'd0);
      check({tag, "_dout"}, 32'(dout_v[j]), 32'd0);
      check({tag, "_shamt"}, 32'(shamt_v[j]), 32'd0);
      check({tag, "_zero"}, 32'(zero_v[j]), 32'd0);
      check({tag, "_limited"}, 32'(limited_v[j]), 32'd0);
      prev_dout[j]  = '0;
      prev_shamt[j] = '0;
    end
  endtask

  initial begin
    logic [W-1:0] rd;
    int sel;
    start_v = 2'b00;
    for (int j = 0; j < 2; j++) begin
      din_v[j] = '0; lim_v[j] = '0; prev_dout[j] = '0; prev_shamt[j] = '0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    reset = 1'b1;

    // directed cases
`ifdef NORM_LIMIT_EN
    run_op(0, 26'h0000001, 5'd3, 1'b0);
    run_op(0, 26'h0000001, 5'd0, 1'b0);
    run_op(1, 26'h0000001, 5'd6, 1'b0);
`endif
    run_op(0, 26'h0000001, 5'd31, 1'b0);
    run_op(0, 26'h2000000, 5'd31, 1'b0);
    run_op(0, 26'h0000000, 5'd31, 1'b0);
    run_op(1, 26'h0000001, 5'd31, 1'b0);
    run_op(1, 26'h0400000, 5'd31, 1'b0);
    run_op(1, 26'h0000000, 5'd31, 1'b0);
    run_op(0, 26'h0000100, 5'd31, 1'b1);
    run_op(1, 26'h0000100, 5'd31, 1'b1);

    // abort with reset while shifting
    @(negedge clk);
    start_v[0] = 1'b1;
    din_v[0]   = 26'h0000001;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_cleared("abort");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_v[0]), 32'd0);
    run_op(0, 26'h1000000, 5'd31, 1'b0);

    // randomized requests
    for (int t = 0; t < 60; t++) begin
      sel = int'($urandom_range(0, 1));
      rd  = W'($urandom) >> $urandom_range(0, W);
      run_op(sel, rd, CW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time bound
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
